// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC job sequencer.
package mac_pkg;

  localparam int unsigned W_BITWIDTH_DEF   = 8;
  localparam int unsigned OUT_BITWIDTH_DEF = 32;
  localparam int unsigned MAX_LEN_DEF      = 16;
  localparam int unsigned LEN_W            = 5;
  localparam int unsigned N_ELEM           = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    CAPT  = 3'd3,
    DRAIN = 3'd4,
    OUT   = 3'd5
  } state_t;

  // LSB of element k inside a packed triple of w-bit elements.
  function automatic int unsigned elem_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/mac_seq_if.sv
// Triple stream, external MAC handshake and result handshake of mac_seq.
interface mac_seq_if #(
  parameter int unsigned W_BITWIDTH   = 8,
  parameter int unsigned OUT_BITWIDTH = 32
);

  localparam int unsigned TRIPLE_W = 3 * W_BITWIDTH;

  logic                    in_valid;
  logic                    in_ready;
  logic [TRIPLE_W-1:0]     in_weights;
  logic [TRIPLE_W-1:0]     in_data;

  logic                    mac_en;
  logic [W_BITWIDTH-1:0]   mac_weights_0;
  logic [W_BITWIDTH-1:0]   mac_weights_1;
  logic [W_BITWIDTH-1:0]   mac_weights_2;
  logic [W_BITWIDTH-1:0]   mac_data_in_0;
  logic [W_BITWIDTH-1:0]   mac_data_in_1;
  logic [W_BITWIDTH-1:0]   mac_data_in_2;
  logic [OUT_BITWIDTH-1:0] mac_pre_sum;
  logic                    mac_done;
  logic [OUT_BITWIDTH-1:0] mac_out;

  logic                    res_valid;
  logic                    res_ready;
  logic [OUT_BITWIDTH-1:0] res_data;

  // Sequencer side.
  modport slave (
    input  in_valid, in_weights, in_data, mac_done, mac_out, res_ready,
    output in_ready, mac_en, mac_weights_0, mac_weights_1, mac_weights_2,
           mac_data_in_0, mac_data_in_1, mac_data_in_2, mac_pre_sum,
           res_valid, res_data
  );

  // Environment side: triple source, MAC and result sink.
  modport master (
    output in_valid, in_weights, in_data, mac_done, mac_out, res_ready,
    input  in_ready, mac_en, mac_weights_0, mac_weights_1, mac_weights_2,
           mac_data_in_0, mac_data_in_1, mac_data_in_2, mac_pre_sum,
           res_valid, res_data
  );

endinterface

// File: rtl/mac_seq.sv
// Dot-product job sequencer: feeds triples to an external 3-way MAC and
// chains each MAC result into the next pre_sum, starting from bias.
module mac_seq
  import mac_pkg::*;
#(
  parameter int unsigned W_BITWIDTH   = W_BITWIDTH_DEF,
  parameter int unsigned OUT_BITWIDTH = OUT_BITWIDTH_DEF,
  parameter int unsigned MAX_LEN      = MAX_LEN_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic [OUT_BITWIDTH-1:0] bias,
  mac_seq_if.slave                bus,
  output logic                    busy,
  output logic                    err_len
);

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
  localparam int unsigned      E0        = elem_lsb(0, W_BITWIDTH);
  localparam int unsigned      E1        = elem_lsb(1, W_BITWIDTH);
  localparam int unsigned      E2        = elem_lsb(2, W_BITWIDTH);

  state_t                  state_q;
  state_t                  state_d;
  logic [OUT_BITWIDTH-1:0] acc_q;
  logic [LEN_W-1:0]        cnt_q;

  logic take;
  logic len_zero;
  logic len_bad;
  logic drain_go;

  assign take     = (state_q == FETCH) && bus.in_valid && bus.in_ready;
  assign len_zero = (len == '0);
  assign len_bad  = (len > MAX_LEN_V);
  assign drain_go = (state_q == DRAIN) && !bus.mac_done;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && !len_bad) state_d = len_zero ? OUT : FETCH;
      end
      FETCH: begin
        if (take) state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.mac_done) state_d = CAPT;
      end
      CAPT: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_go) state_d = (cnt_q == ONE) ? OUT : FETCH;
      end
      OUT: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; status flags track the next state so
  // they line up with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q             <= '0;
      cnt_q             <= '0;
      bus.in_ready      <= 1'b0;
      bus.mac_en        <= 1'b0;
      bus.mac_weights_0 <= '0;
      bus.mac_weights_1 <= '0;
      bus.mac_weights_2 <= '0;
      bus.mac_data_in_0 <= '0;
      bus.mac_data_in_1 <= '0;
      bus.mac_data_in_2 <= '0;
      bus.mac_pre_sum   <= '0;
      bus.res_valid     <= 1'b0;
      bus.res_data      <= '0;
      busy              <= 1'b0;
      err_len           <= 1'b0;
    end else begin
      bus.in_ready  <= (state_d == FETCH);
      bus.mac_en    <= (state_d == ISSUE);
      bus.res_valid <= (state_d == OUT);
      busy          <= (state_d != IDLE);
      err_len       <= (state_q == IDLE) && start && len_bad;

      if ((state_q == IDLE) && start && !len_bad) begin
        acc_q <= bias;
        cnt_q <= len;
        if (len_zero) bus.res_data <= bias;
      end

      if (take) begin
        bus.mac_weights_0 <= bus.in_weights[E0 +: W_BITWIDTH];
        bus.mac_weights_1 <= bus.in_weights[E1 +: W_BITWIDTH];
        bus.mac_weights_2 <= bus.in_weights[E2 +: W_BITWIDTH];
        bus.mac_data_in_0 <= bus.in_data[E0 +: W_BITWIDTH];
        bus.mac_data_in_1 <= bus.in_data[E1 +: W_BITWIDTH];
        bus.mac_data_in_2 <= bus.in_data[E2 +: W_BITWIDTH];
        bus.mac_pre_sum   <= acc_q;
      end

      // mac_out is valid from the second done-high cycle.
      if (state_q == CAPT) acc_q <= bus.mac_out;

      if (drain_go) begin
        cnt_q <= cnt_q - ONE;
        if (cnt_q == ONE) bus.res_data <= acc_q;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq with a cycle-accurate external MAC model.
module tb_mac_seq;
  import mac_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned OW = 32;

  logic          clk   = 1'b0;
  logic          rstn  = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    len   = '0;
  logic [OW-1:0] bias  = '0;
  logic          busy;
  logic          err_len;

  mac_seq_if #(.W_BITWIDTH(W), .OUT_BITWIDTH(OW)) bus ();

  mac_seq #(.W_BITWIDTH(W), .OUT_BITWIDTH(OW), .MAX_LEN(16)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .len     (len),
    .bias    (bias),
    .bus     (bus.slave),
    .busy    (busy),
    .err_len (err_len)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [23:0] pack3(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [31:0] dot3(input logic [23:0] w, input logic [23:0] d);
    int s;
    s = 0;
    for (int k = 0; k < 3; k++)
      s += int'($signed(w[8*k +: 8])) * int'($signed(d[8*k +: 8]));
    return 32'(s);
  endfunction

  // MAC model: done 9 cycles after accepted mac_en, held 3 cycles, out from 2nd.
  int          mcnt;
  int          dcnt;
  logic        mbusy;
  logic [31:0] mres;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcnt         <= 0;
      dcnt         <= 0;
      mbusy        <= 1'b0;
      mres         <= '0;
      bus.mac_done <= 1'b0;
      bus.mac_out  <= '0;
    end else begin
      if (!mbusy && dcnt == 0 && bus.mac_en) begin
        mbusy <= 1'b1;
        mcnt  <= 1;
        mres  <= bus.mac_pre_sum +
                 dot3({bus.mac_weights_2, bus.mac_weights_1, bus.mac_weights_0},
                      {bus.mac_data_in_2, bus.mac_data_in_1, bus.mac_data_in_0});
      end else if (mbusy) begin
        if (mcnt == 9) begin
          mbusy        <= 1'b0;
          dcnt         <= 1;
          bus.mac_done <= 1'b1;
        end else begin
          mcnt <= mcnt + 1;
        end
      end
      if (dcnt != 0) begin
        if (dcnt == 3) begin
          dcnt         <= 0;
          bus.mac_done <= 1'b0;
        end else begin
          dcnt <= dcnt + 1;
        end
        if (dcnt == 1) bus.mac_out <= mres;
      end
    end
  end

  // mac_en episode counter and the pre_sum seen at each episode start.
  int          mac_eps = 0;
  logic        mac_en_q = 1'b0;
  logic [31:0] presum_log[$];
  always @(posedge clk) begin
    if (bus.mac_en && !mac_en_q) begin
      mac_eps <= mac_eps + 1;
      presum_log.push_back(bus.mac_pre_sum);
    end
    mac_en_q <= bus.mac_en;
  end

  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] b, input logic [4:0] l);
    @(negedge clk);
    start = 1'b1;
    bias  = b;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_triple(input logic [23:0] w, input logic [23:0] d);
    bit ok;
    ok = 1'b0;
    bus.in_weights = w;
    bus.in_data    = d;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (bus.res_valid) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) chk("res_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic get_result(input string nm);
    bit ok;
    wait_res(ok);
    if (ok) begin
      if (exp_q.size() == 0) chk({nm, "_no_expect"}, 32'd1, 32'd0);
      else chk(nm, bus.res_data, exp_q.pop_front());
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk({nm, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] b;
    logic [23:0] w;
    logic [23:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          eps0;
    bit          ok;
    logic [31:0] held;

    vt[0] = '{32'd100,       pack3(1, 2, 3),          pack3(4, 5, 6),          32'd132};
    vt[1] = '{32'd0,         pack3(-1, -2, -3),       pack3(4, 5, 6),          32'hFFFF_FFE0};
    vt[2] = '{32'hFFFF_FFCE, pack3(127, -128, 0),     pack3(-128, -128, 99),   32'd78};
    vt[3] = '{32'h7FFF_FFF0, pack3(127, 127, 127),    pack3(127, 127, 127),    32'h8000_BCF3};
    vt[4] = '{32'hFFFF_FFFF, pack3(-128, -128, -128), pack3(-128, -128, -128), 32'd49151};

    bus.in_valid   = 1'b0;
    bus.in_weights = '0;
    bus.in_data    = '0;
    bus.res_ready  = 1'b0;

    #12;
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_err_len",   32'(err_len),       32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data",  bus.res_data,       32'd0);
    chk("rst_mac_en",    32'(bus.mac_en),    32'd0);
    chk("rst_pre_sum",   bus.mac_pre_sum,    32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Single-triple jobs from the table.
    for (int i = 0; i < 5; i++) begin
      eps0 = mac_eps;
      exp_q.push_back(vt[i].exp);
      start_job(vt[i].b, 5'd1);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      send_triple(vt[i].w, vt[i].d);
      get_result($sformatf("vec%0d_res", i));
      chk($sformatf("vec%0d_eps", i), 32'(mac_eps - eps0), 32'd1);
    end

    // Two-triple chaining.
    presum_log.delete();
    eps0 = mac_eps;
    exp_q.push_back(32'd126);
    start_job(32'd100, 5'd2);
    send_triple(pack3(1, 2, 3), pack3(4, 5, 6));
    send_triple(pack3(-1, -1, -1), pack3(2, 2, 2));
    get_result("chain_res");
    chk("chain_eps", 32'(mac_eps - eps0), 32'd2);
    if (presum_log.size() == 2) begin
      chk("chain_presum0", presum_log[0], 32'd100);
      chk("chain_presum1", presum_log[1], 32'd132);
    end else begin
      chk("chain_presum_count", 32'(presum_log.size()), 32'd2);
    end

    // Empty job goes straight to the result.
    eps0 = mac_eps;
    start_job(32'hFFFF_FFF9, 5'd0);
    chk("empty_valid_next", 32'(bus.res_valid), 32'd1);
    exp_q.push_back(32'hFFFF_FFF9);
    get_result("empty_res");
    chk("empty_no_mac", 32'(mac_eps - eps0), 32'd0);

    // Result back-pressure with start/in_valid noise.
    exp_q.push_back(32'd132);
    start_job(32'd100, 5'd1);
    send_triple(pack3(1, 2, 3), pack3(4, 5, 6));
    wait_res(ok);
    if (ok) begin
      held = bus.res_data;
      for (int i = 0; i < 5; i++) begin
        start        = 1'b1;
        len          = 5'd1;
        bias         = 32'd55;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk($sformatf("bp_hold%0d", i), bus.res_data, held);
        chk($sformatf("bp_in_ready%0d", i), 32'(bus.in_ready), 32'd0);
        chk($sformatf("bp_valid%0d", i), 32'(bus.res_valid), 32'd1);
      end
      start        = 1'b0;
      bus.in_valid = 1'b0;
      get_result("bp_res");
      chk("bp_idle0", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      chk("bp_idle2", 32'(busy), 32'd0);
    end

    // Illegal length.
    start_job(32'd5, 5'd20);
    chk("bad_len_pulse", 32'(err_len), 32'd1);
    chk("bad_len_busy0", 32'(busy),    32'd0);
    @(negedge clk);
    chk("bad_len_drop",  32'(err_len), 32'd0);
    chk("bad_len_busy1", 32'(busy),    32'd0);

    // Reset while the MAC is running.
    start_job(32'd100, 5'd1);
    send_triple(pack3(1, 2, 3), pack3(4, 5, 6));
    repeat (3) @(negedge clk);
    chk("mid_mac_en", 32'(bus.mac_en), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_mac_en",    32'(bus.mac_en),    32'd0);
    chk("mid_rst_busy",      32'(busy),          32'd0);
    chk("mid_rst_pre_sum",   bus.mac_pre_sum,    32'd0);
    chk("mid_rst_w0",        32'(bus.mac_weights_0), 32'd0);
    chk("mid_rst_d2",        32'(bus.mac_data_in_2), 32'd0);
    chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_res_data",  bus.res_data,       32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_no_result", 32'(bus.res_valid), 32'd0);
    exp_q.push_back(32'd78);
    start_job(32'hFFFF_FFCE, 5'd1);
    send_triple(pack3(127, -128, 0), pack3(-128, -128, 99));
    get_result("post_rst_res");

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 SHALL have parameter W_BITWIDTH, default 8: width of each weight and data element.
REQ-002 SHALL have parameter OUT_BITWIDTH, default 32: width of pre_sum, MAC result, bias and final result.
REQ-003 SHALL have parameter MAX_LEN, default 16: maximum triples per job.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle job request; sampled in IDLE only.
REQ-007 len  in  5  triples in the job, sampled with start.
REQ-008 bias  in  OUT_BITWIDTH  signed job seed, sampled with start.
REQ-009 in_valid / in_ready  in / out  1 / 1  triple-stream handshake.
REQ-010 in_weights, in_data  in  3*W_BITWIDTH each  element k in bits [8k+7:8k], signed.
REQ-011 mac_en  out  1  MAC start request.
REQ-012 mac_weights_0..2, mac_data_in_0..2  out  W_BITWIDTH each  MAC operands.
REQ-013 mac_pre_sum  out  OUT_BITWIDTH  MAC accumulate seed.
REQ-014 mac_done, mac_out  in  1, OUT_BITWIDTH  MAC completion flag and signed result.
REQ-015 res_valid / res_ready  out / in  1 / 1  result handshake; res_data  out  OUT_BITWIDTH  signed dot product.
REQ-016 busy  out  1  high whenever state is not IDLE; err_len  out  1  one-cycle pulse on rejected len.

Function
REQ-017 SHALL compute res_data = bias + sum over len triples of (w0*d0 + w1*d1 + w2*d2), chaining each MAC result as the next mac_pre_sum.
REQ-018 States: IDLE, FETCH, ISSUE, CAPT, DRAIN, OUT.
REQ-019 IDLE: on start with 1<=len<=MAX_LEN, latch bias into the accumulator and len into the remaining counter, then go to FETCH.
REQ-020 IDLE: start with len=0 SHALL go to OUT with res_data=bias and issue no MAC operation.
REQ-021 IDLE: start with len>MAX_LEN SHALL pulse err_len for one cycle and remain in IDLE.
REQ-022 FETCH: in_ready=1; on in_valid&&in_ready, register the triple onto the mac_* operands, drive mac_pre_sum from the accumulator, and go to ISSUE.
REQ-023 in_ready SHALL be 0 in every state other than FETCH.
REQ-024 ISSUE: mac_en=1, entered only while mac_done=0; on the first cycle mac_done=1, drop mac_en and go to CAPT.
REQ-025 Operand and pre_sum outputs SHALL be held stable from ISSUE entry until leaving CAPT.
REQ-026 CAPT: accumulator <= mac_out on the cycle after the first mac_done=1 (second consecutive done-high cycle), then go to DRAIN.
REQ-027 DRAIN: wait for mac_done=0, then decrement the remaining counter; go to FETCH if the counter is nonzero, else go to OUT.
REQ-028 OUT: res_valid=1 and res_data=accumulator, held stable until res_ready; on res_valid&&res_ready go to IDLE.
REQ-029 start outside IDLE SHALL be ignored; in_valid outside FETCH SHALL be ignored.
REQ-030 Accumulation SHALL be OUT_BITWIDTH two's-complement and wrap on overflow, with no saturation.
REQ-031 Controller overhead beyond the MAC handshake SHALL be at most 3 cycles per triple.

Reset
REQ-032 rstn low SHALL asynchronously force IDLE and clear to 0 mac_en, operands, mac_pre_sum, accumulator, counter, in_ready, res_valid, res_data, busy and err_len.
REQ-033 Reset mid-job SHALL abandon the job with no result emitted; the first start after reset SHALL behave as a fresh job.

Structure
REQ-034 The state enum, MAX_LEN default and the bit-slice positions of the packed triples SHALL live in the shared package mac_pkg.
REQ-035 SHALL contain no sub-module; the MAC is instantiated alongside mac_seq by the parent, not inside it.

Verification
REQ-036 The bench SHALL use a cycle-accurate MAC model: 9 cycles from accepted mac_en to done, done held 3 cycles, and out valid from the second done cycle.
REQ-037 Single triple: bias=100, w=(1,2,3), d=(4,5,6), len=1 -> one mac_en episode, res_data=132.
REQ-038 Chaining: len=2, second triple w=(-1,-1,-1), d=(2,2,2) -> second mac_pre_sum=132, res_data=126.
REQ-039 Empty job: len=0, bias=-7 -> res_valid on the next cycle, res_data=-7, mac_en never asserted.
REQ-040 Back-pressure: res_ready held 0 for 5 cycles -> res_data stable, no start accepted, in_ready=0 throughout.
REQ-041 Illegal length: len=20 -> err_len for exactly one cycle, busy stays 0.
REQ-042 Reset mid-ISSUE -> all outputs 0 immediately; a following job with len=1 gives the correct result.
